// File: rtl/sbp_lookup_stage_hs_if.sv
// ---------------------------------------------------------------------------
// sbp_lookup_stage_hs_if
// Valid/ready item stream between longest-prefix-match tree stages.
//   valid / ready : handshake, transfer when both high
//   update        : 1 = node write request, 0 = lookup
//   ip_addr       : address being looked up, or prefix to write
//   bit_pos       : next bit to test, or prefix length to write
//   stage_id      : target stage (0 = lookup finished)
//   location      : target node inside the stage
//   result        : {stage, location, flags[1:0]}
// master drives the item, slave returns ready.
// ---------------------------------------------------------------------------
interface sbp_lookup_stage_hs_if #(
    parameter int STAGE_ID_BITS = 6,
    parameter int LOCATION_BITS = 11,
    parameter int IP_BITS       = 32
);
    localparam int LEN_BITS    = $clog2(IP_BITS) + 1;
    localparam int RESULT_BITS = STAGE_ID_BITS + LOCATION_BITS + 2;

    logic                     valid;
    logic                     ready;
    logic                     update;
    logic [IP_BITS-1:0]       ip_addr;
    logic [LEN_BITS-1:0]      bit_pos;
    logic [STAGE_ID_BITS-1:0] stage_id;
    logic [LOCATION_BITS-1:0] location;
    logic [RESULT_BITS-1:0]   result;

    modport master (
        output valid, update, ip_addr, bit_pos, stage_id, location, result,
        input  ready
    );

    modport slave (
        input  valid, update, ip_addr, bit_pos, stage_id, location, result,
        output ready
    );
endinterface

// File: rtl/sbp_lookup_stage_hs.sv
// ---------------------------------------------------------------------------
// sbp_lookup_stage_hs
// One flow-controlled stage of the pipelined longest-prefix-match tree.
// Selected updates write the node word into the external RAM in the accept
// cycle; selected lookups read the node and are evaluated when the read data
// returns. Every item (selected or not) then lands in a small output FIFO.
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   in_i  (slave)   : upstream item stream
//   out_o (master)  : downstream item stream, driven by the FIFO head
//   mem_rd_en_o     : RAM read strobe (accept cycle of a selected lookup)
//   mem_wr_en_o     : RAM write strobe (accept cycle of a selected update)
//   mem_addr_o      : RAM address (= in location)
//   mem_wdata_o     : RAM write data {prefix, prefix_len, result}
//   mem_rdata_i     : RAM read data, valid MEM_LATENCY cycles after the read
// ---------------------------------------------------------------------------
module sbp_lookup_stage_hs #(
    parameter int STAGE_ID      = 1,
    parameter int STAGE_ID_BITS = 6,
    parameter int LOCATION_BITS = 11,
    parameter int IP_BITS       = 32,
    parameter int MEM_LATENCY   = 1,
    localparam int LEN_BITS     = $clog2(IP_BITS) + 1,
    localparam int RESULT_BITS  = STAGE_ID_BITS + LOCATION_BITS + 2,
    localparam int DATA_BITS    = IP_BITS + LEN_BITS + RESULT_BITS,
    localparam int FIFO_DEPTH   = MEM_LATENCY + 2
) (
    input  logic                     clk,
    input  logic                     rst,
    sbp_lookup_stage_hs_if.slave     in_i,
    sbp_lookup_stage_hs_if.master    out_o,
    output logic                     mem_rd_en_o,
    output logic                     mem_wr_en_o,
    output logic [LOCATION_BITS-1:0] mem_addr_o,
    output logic [DATA_BITS-1:0]     mem_wdata_o,
    input  logic [DATA_BITS-1:0]     mem_rdata_i
);
    localparam int PTR_BITS = $clog2(FIFO_DEPTH);
    localparam int CNT_BITS = $clog2(FIFO_DEPTH + 1);
    localparam logic [CNT_BITS-1:0] DEPTH_C    = CNT_BITS'(FIFO_DEPTH);
    localparam logic [PTR_BITS-1:0] PTR_LAST_C = PTR_BITS'(FIFO_DEPTH - 1);
    localparam logic [LEN_BITS-1:0] IP_LEN_C   = LEN_BITS'(IP_BITS);

    typedef struct packed {
        logic                     update;
        logic [IP_BITS-1:0]       ip;
        logic [LEN_BITS-1:0]      bit_pos;
        logic [STAGE_ID_BITS-1:0] stage_id;
        logic [LOCATION_BITS-1:0] location;
        logic [RESULT_BITS-1:0]   result;
    } item_t;

    logic [MEM_LATENCY-1:0] pipe_vld_q, pipe_eval_q;
    item_t                  pipe_q [MEM_LATENCY];
    item_t                  fifo_q [FIFO_DEPTH];
    logic [PTR_BITS-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_BITS-1:0]    fifo_cnt_q, fifo_cnt_d;
    logic [CNT_BITS-1:0]    cnt_q, cnt_d;

    item_t in_item, cur, eval_item, out_item;
    logic  in_rdy, accept, sel, push, pop, out_vld;

    // Upstream side: ready only from registers, so no path from out_o.ready.
    assign in_rdy  = !rst && (cnt_q < DEPTH_C);
    assign accept  = in_i.valid && in_rdy;
    assign sel     = (in_i.stage_id == STAGE_ID_BITS'(STAGE_ID));
    assign in_item = {in_i.update, in_i.ip_addr, in_i.bit_pos, in_i.stage_id,
                      in_i.location, in_i.result};
    assign in_i.ready = in_rdy;

    assign mem_wr_en_o = accept && sel && in_i.update;
    assign mem_rd_en_o = accept && sel && !in_i.update;
    assign mem_addr_o  = in_i.location;
    assign mem_wdata_o = {in_i.ip_addr, in_i.bit_pos, in_i.result};

    // Node word as stored: {prefix, prefix_len, child_stage, child_loc, has_left, has_right}
    logic [IP_BITS-1:0]       rd_prefix, match_mask;
    logic [LEN_BITS-1:0]      rd_len, eff_len;
    logic [STAGE_ID_BITS-1:0] rd_child_stage;
    logic [LOCATION_BITS-1:0] rd_child_loc;
    logic                     rd_has_left, rd_has_right, go_right, prefix_match, has_child;

    assign {rd_prefix, rd_len, rd_child_stage, rd_child_loc, rd_has_left, rd_has_right} = mem_rdata_i;
    assign cur = pipe_q[MEM_LATENCY-1];

    always_comb begin
        eff_len    = (rd_len > IP_LEN_C) ? IP_LEN_C : rd_len;
        match_mask = '0;
        go_right   = 1'b0;
        // Mask covers the top eff_len bits; bit_pos beyond the address leaves go_right at 0.
        for (int i = 0; i < IP_BITS; i++) begin
            match_mask[IP_BITS-1-i] = (LEN_BITS'(i) < eff_len);
            if (cur.bit_pos == LEN_BITS'(i)) begin
                go_right = cur.ip[IP_BITS-1-i];
            end
        end
        prefix_match = (((cur.ip ^ rd_prefix) & match_mask) == '0);
        has_child    = (cur.bit_pos < IP_LEN_C) &&
                       ((rd_has_left && !go_right) || (rd_has_right && go_right));

        eval_item = cur;
        if (pipe_eval_q[MEM_LATENCY-1]) begin
            eval_item.stage_id = has_child ? rd_child_stage : '0;
            eval_item.location = has_child ? rd_child_loc + LOCATION_BITS'(go_right)
                                           : cur.location;
            eval_item.bit_pos  = (cur.bit_pos >= IP_LEN_C) ? IP_LEN_C
                                                           : cur.bit_pos + LEN_BITS'(1);
            eval_item.result   = prefix_match ? {STAGE_ID_BITS'(STAGE_ID), cur.location, 2'b10}
                                              : cur.result;
        end
    end

    // Output FIFO; the credit counter guarantees a free slot for every push.
    assign push    = pipe_vld_q[MEM_LATENCY-1];
    assign out_vld = (fifo_cnt_q != '0);
    assign pop     = out_vld && out_o.ready;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        fifo_cnt_d = fifo_cnt_q;
        cnt_d      = cnt_q;
        if (push) begin
            wr_ptr_d = (wr_ptr_q == PTR_LAST_C) ? '0 : wr_ptr_q + PTR_BITS'(1);
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == PTR_LAST_C) ? '0 : rd_ptr_q + PTR_BITS'(1);
        end
        case ({push, pop})
            2'b10:   fifo_cnt_d = fifo_cnt_q + CNT_BITS'(1);
            2'b01:   fifo_cnt_d = fifo_cnt_q - CNT_BITS'(1);
            default: fifo_cnt_d = fifo_cnt_q;
        endcase
        case ({accept, pop})
            2'b10:   cnt_d = cnt_q + CNT_BITS'(1);
            2'b01:   cnt_d = cnt_q - CNT_BITS'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pipe_vld_q  <= '0;
            pipe_eval_q <= '0;
            for (int k = 0; k < MEM_LATENCY; k++) pipe_q[k] <= '0;
            for (int k = 0; k < FIFO_DEPTH; k++)  fifo_q[k] <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            fifo_cnt_q  <= '0;
            cnt_q       <= '0;
        end else begin
            pipe_vld_q[0]  <= accept;
            pipe_eval_q[0] <= accept && sel && !in_i.update;
            pipe_q[0]      <= in_item;
            for (int k = 1; k < MEM_LATENCY; k++) begin
                pipe_vld_q[k]  <= pipe_vld_q[k-1];
                pipe_eval_q[k] <= pipe_eval_q[k-1];
                pipe_q[k]      <= pipe_q[k-1];
            end
            if (push) begin
                fifo_q[wr_ptr_q] <= eval_item;
            end
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            fifo_cnt_q <= fifo_cnt_d;
            cnt_q      <= cnt_d;
        end
    end

    // Data outputs read as zero whenever nothing is presented.
    assign out_item       = out_vld ? fifo_q[rd_ptr_q] : '0;
    assign out_o.valid    = out_vld;
    assign out_o.update   = out_item.update;
    assign out_o.ip_addr  = out_item.ip;
    assign out_o.bit_pos  = out_item.bit_pos;
    assign out_o.stage_id = out_item.stage_id;
    assign out_o.location = out_item.location;
    assign out_o.result   = out_item.result;
endmodule
